// File: rtl/spi_accel_slave.sv
// SPI mode-3 register slave exposing an accelerometer-style register map.
// Define SPI_SLAVE_MB_EN to enable multi-byte bursts with address auto-increment.
module spi_accel_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       ncs,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_axis,
    input  logic [9:0] y_axis,
    input  logic [9:0] z_axis,
    output logic [7:0] power_ctl,
    output logic [7:0] data_format,
    output logic       wr_strobe
);

    typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

    state_e          state_q, state_d;
    logic            ncs_meta, ncs_sync, ncs_prev;
    logic            sclk_meta, sclk_sync, sclk_prev;
    logic            mosi_meta, mosi_sync;
    logic            ncs_fall, ncs_rise, sclk_fall, sclk_rise;
    logic [2:0]      bit_cnt_q;
    logic [6:0]      rx_q;
    logic [7:0]      rx_byte;
    logic [7:0]      tx_q;
    logic            miso_q;
    logic            rnw_q;
    logic            active_q;
    logic            more_ok;
    logic [5:0]      addr_q;
    logic [5:0]      rd_addr;
    logic [7:0]      rd_data;
    logic [5:0][7:0] snap_q;
    logic            wr_pend_q;
    logic [5:0]      wr_addr_q;
    logic [7:0]      wr_data_q;
    logic [7:0]      power_ctl_q, data_format_q;
    logic            wr_strobe_q;

    // Synchronizers reset to the idle bus levels so release of reset does not fake an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ncs_meta  <= 1'b1;
            ncs_sync  <= 1'b1;
            ncs_prev  <= 1'b1;
            sclk_meta <= 1'b1;
            sclk_sync <= 1'b1;
            sclk_prev <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            ncs_meta  <= ncs;
            ncs_sync  <= ncs_meta;
            ncs_prev  <= ncs_sync;
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign ncs_fall  = ncs_prev & ~ncs_sync;
    assign ncs_rise  = ~ncs_prev & ncs_sync;
    assign sclk_fall = sclk_prev & ~sclk_sync;
    assign sclk_rise = ~sclk_prev & sclk_sync;
    assign rx_byte   = {rx_q, mosi_sync};

`ifdef SPI_SLAVE_MB_EN
    logic mb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mb_q <= 1'b0;
        end else if (state_q == StCmd && sclk_rise && bit_cnt_q == 3'd7 && !ncs_rise) begin
            mb_q <= rx_byte[6];
        end
    end

    assign more_ok = mb_q;
`else
    assign more_ok = 1'b0;
`endif

    // During the command byte the address comes straight off the wire; afterwards it is the
    // next burst address.
    assign rd_addr = (state_q == StCmd) ? rx_byte[5:0] : addr_q + 6'd1;

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            6'h00:   rd_data = 8'hE5;
            6'h2D:   rd_data = power_ctl_q;
            6'h31:   rd_data = data_format_q;
            6'h32:   rd_data = snap_q[0];
            6'h33:   rd_data = snap_q[1];
            6'h34:   rd_data = snap_q[2];
            6'h35:   rd_data = snap_q[3];
            6'h36:   rd_data = snap_q[4];
            6'h37:   rd_data = snap_q[5];
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (ncs_fall) state_d = StCmd;
            StCmd:   if (sclk_rise && bit_cnt_q == 3'd7) state_d = StData;
            StData:  state_d = StData;
            default: state_d = StIdle;
        endcase
        if (ncs_rise) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q     <= 3'd0;
            rx_q          <= 7'd0;
            tx_q          <= 8'd0;
            miso_q        <= 1'b0;
            rnw_q         <= 1'b0;
            active_q      <= 1'b0;
            addr_q        <= 6'd0;
            snap_q        <= '0;
            wr_pend_q     <= 1'b0;
            wr_addr_q     <= 6'd0;
            wr_data_q     <= 8'd0;
            power_ctl_q   <= 8'h00;
            data_format_q <= 8'h00;
            wr_strobe_q   <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            wr_pend_q   <= 1'b0;
            // A completed byte commits even if ncs rises right behind it.
            if (wr_pend_q) begin
                case (wr_addr_q)
                    6'h2D: begin
                        power_ctl_q <= wr_data_q;
                        wr_strobe_q <= 1'b1;
                    end
                    6'h31: begin
                        data_format_q <= wr_data_q;
                        wr_strobe_q   <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (ncs_rise) begin
                bit_cnt_q <= 3'd0;
                rx_q      <= 7'd0;
                tx_q      <= 8'd0;
                miso_q    <= 1'b0;
                active_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (ncs_fall) begin
                            bit_cnt_q <= 3'd0;
                            rx_q      <= 7'd0;
                            miso_q    <= 1'b0;
                            snap_q    <= {{6{z_axis[9]}}, z_axis[9:8], z_axis[7:0],
                                          {6{y_axis[9]}}, y_axis[9:8], y_axis[7:0],
                                          {6{x_axis[9]}}, x_axis[9:8], x_axis[7:0]};
                        end
                    end
                    StCmd: begin
                        if (sclk_rise) begin
                            rx_q      <= rx_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rnw_q    <= rx_byte[7];
                                addr_q   <= rx_byte[5:0];
                                active_q <= 1'b1;
                                tx_q     <= rx_byte[7] ? rd_data : 8'h00;
                            end
                        end
                    end
                    StData: begin
                        if (sclk_fall) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            rx_q      <= rx_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (active_q && !rnw_q) begin
                                    wr_pend_q <= 1'b1;
                                    wr_addr_q <= addr_q;
                                    wr_data_q <= rx_byte;
                                end
                                addr_q   <= addr_q + 6'd1;
                                active_q <= active_q & more_ok;
                                tx_q     <= (rnw_q && active_q && more_ok) ? rd_data : 8'h00;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign miso        = miso_q;
    assign power_ctl   = power_ctl_q;
    assign data_format = data_format_q;
    assign wr_strobe   = wr_strobe_q;

endmodule

// File: tb/tb_spi_accel_slave.sv
// Scoreboard bench for spi_accel_slave: an SPI master task feeds expected read bytes and
// register writes into queues checked by independent monitors.
`timescale 1ns/1ps
module tb_spi_accel_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ncs = 1'b1;
    logic       sclk = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [9:0] x_axis = 10'd0;
    logic [9:0] y_axis = 10'd0;
    logic [9:0] z_axis = 10'd0;
    logic [7:0] power_ctl;
    logic [7:0] data_format;
    logic       wr_strobe;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_rd[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  got_byte;
    event        got_ev;

    spi_accel_slave dut (
        .clk        (clk),
        .rst        (rst),
        .ncs        (ncs),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .x_axis     (x_axis),
        .y_axis     (y_axis),
        .z_axis     (z_axis),
        .power_ctl  (power_ctl),
        .data_format(data_format),
        .wr_strobe  (wr_strobe)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Read-byte monitor.
    initial begin
        logic [7:0] e;
        forever begin
            @(got_ev);
            if (exp_rd.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got %02h expected no byte", got_byte);
            end else begin
                e = exp_rd.pop_front();
                check8("rd_byte", got_byte, e);
            end
        end
    end

    // Write-commit monitor, sampled on the falling clk edge.
    always @(negedge clk) begin
        logic [15:0] e;
        if (wr_strobe === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected: got pc=%02h df=%02h expected no strobe",
                         power_ctl, data_format);
            end else begin
                e = exp_wr.pop_front();
                check8("wr_power_ctl", power_ctl, e[15:8]);
                check8("wr_data_format", data_format, e[7:0]);
            end
        end
    end

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 1'b0;
            mosi = tx[i];
            #80;
            sclk = 1'b1;
            rx[i] = miso;
            #80;
        end
    endtask

    // Data bytes 0..3 come from wd (MSB byte first); later bytes send 0x00.
    task automatic xfer(input logic [7:0] cmd, input int nbytes, input logic [31:0] wd,
                        input int last_bits);
        logic [7:0] r;
        logic [7:0] d;
        int         nb;
        @(negedge clk);
        ncs = 1'b0;
        #100;
        spi_byte(cmd, 8, r);
        for (int b = 0; b < nbytes; b++) begin
            d  = (b < 4) ? wd[31 - 8 * b -: 8] : 8'h00;
            nb = (b == nbytes - 1) ? last_bits : 8;
            spi_byte(d, nb, r);
            if (cmd[7]) begin
                got_byte = r;
                ->got_ev;
            end
        end
        #100;
        ncs  = 1'b1;
        mosi = 1'b0;
        #300;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check8("rst_power_ctl", power_ctl, 8'h00);
        check8("rst_data_format", data_format, 8'h00);
        check8("rst_miso", {7'd0, miso}, 8'h00);
        check8("rst_wr_strobe", {7'd0, wr_strobe}, 8'h00);

        exp_rd.push_back(8'hE5);
        xfer(8'h80, 1, 32'h0, 8);

        exp_wr.push_back({8'h08, 8'h00});
        xfer(8'h2D, 1, 32'h0800_0000, 8);
        check8("pc_after_write", power_ctl, 8'h08);
        exp_rd.push_back(8'h08);
        xfer(8'hAD, 1, 32'h0, 8);

        exp_wr.push_back({8'h08, 8'h0B});
        xfer(8'h31, 1, 32'h0B00_0000, 8);
        exp_rd.push_back(8'h0B);
        xfer(8'hB1, 1, 32'h0, 8);

        x_axis = 10'h201;
        y_axis = 10'h0FF;
        z_axis = 10'h3FF;
`ifdef SPI_SLAVE_MB_EN
        exp_rd.push_back(8'h01); exp_rd.push_back(8'hFE); exp_rd.push_back(8'hFF);
        exp_rd.push_back(8'h00); exp_rd.push_back(8'hFF); exp_rd.push_back(8'hFF);
        fork
            xfer(8'hF2, 6, 32'h0, 8);
            begin
                #3000;
                x_axis = 10'h000;
                y_axis = 10'h000;
                z_axis = 10'h000;
            end
        join
`else
        exp_rd.push_back(8'h01); exp_rd.push_back(8'h00);
        fork
            xfer(8'hF2, 2, 32'h0, 8);
            begin
                #1500;
                x_axis = 10'h000;
                y_axis = 10'h000;
                z_axis = 10'h000;
            end
        join
`endif
        exp_rd.push_back(8'h00);
        xfer(8'hB2, 1, 32'h0, 8);

        xfer(8'h31, 1, 32'h5500_0000, 5);
        check8("df_after_partial", data_format, 8'h0B);
        check8("miso_idle", {7'd0, miso}, 8'h00);
        exp_rd.push_back(8'hE5);
        xfer(8'h80, 1, 32'h0, 8);

`ifdef SPI_SLAVE_MB_EN
        exp_rd.push_back(8'h00); exp_rd.push_back(8'hE5);
`else
        exp_rd.push_back(8'h00); exp_rd.push_back(8'h00);
`endif
        xfer(8'hFF, 2, 32'h0, 8);

        xfer(8'h00, 1, 32'h5500_0000, 8);
        xfer(8'h10, 1, 32'h5500_0000, 8);
        check8("pc_after_ro_write", power_ctl, 8'h08);
        check8("df_after_ro_write", data_format, 8'h0B);
        exp_rd.push_back(8'h00);
        xfer(8'h90, 1, 32'h0, 8);

        exp_wr.push_back({8'h01, 8'h0B});
        xfer(8'h6D, 2, 32'h0102_0000, 8);
        check8("pc_after_burst_write", power_ctl, 8'h01);

        @(negedge clk);
        ncs = 1'b0;
        #100;
        spi_byte(8'h2D, 8, r);
        spi_byte(8'hAA, 4, r);
        rst = 1'b0;
        #50;
        ncs  = 1'b1;
        sclk = 1'b1;
        mosi = 1'b0;
        #100;
        rst = 1'b1;
        #200;
        check8("pc_after_midreset", power_ctl, 8'h00);
        check8("df_after_midreset", data_format, 8'h00);
        check8("miso_after_midreset", {7'd0, miso}, 8'h00);
        exp_rd.push_back(8'hE5);
        xfer(8'h80, 1, 32'h0, 8);
        exp_rd.push_back(8'h00);
        xfer(8'hAD, 1, 32'h0, 8);

        #500;
        checks++;
        if (exp_rd.size() != 0) begin
            failures++;
            $display("FAIL rd_pending: got %0d left expected 0", exp_rd.size());
        end
        checks++;
        if (exp_wr.size() != 0) begin
            failures++;
            $display("FAIL wr_pending: got %0d left expected 0", exp_wr.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
